div_iter_unit: RTL and testbench
================================

Name: div_iter_unit

Overview:
- Multi-cycle radix-2 restoring integer divider for the CPU execute stage.
- Serves as the iterative counterpart to the combinational prefix-tree adder: it consumes one subtract/compare per cycle instead of resolving carries in one pass.
- Accepts operands with a valid/ready handshake, iterates one quotient bit per cycle, and returns quotient and remainder with RISC-V divide semantics.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, >= 4)
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- dividend  input  WIDTH  numerator
- divisor  input  WIDTH  denominator
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  result quotient
- remainder  output  WIDTH  result remainder
- div_by_zero  output  1  flag, valid with out_valid
- flush  input  1  abort in-flight op (present only with DIV_FLUSH_EN)

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - A transfer occurs when in_valid&&in_ready. On that edge the unit latches:
    - the magnitudes of both operands (abs value if is_signed and MSB set),
    - the sign of the quotient (sign_dd XOR sign_dv),
    - the sign of the remainder (sign_dd).
  - After latching:
    - divisor==0: go directly to DONE with quotient = all ones, remainder = raw dividend, div_by_zero=1.
    - signed overflow (dividend = 100..0, divisor = all ones, is_signed): go directly to DONE with quotient = dividend, remainder = 0.
    - otherwise: go to CALC with counter=WIDTH and the partial remainder cleared.
- CALC:
  - in_ready=0.
  - Each cycle:
    - shift {partial remainder, dividend magnitude} left by 1;
    - trial = partial remainder − divisor magnitude, computed in WIDTH+1 bits;
    - if no borrow, commit trial and set the quotient LSB to 1, else set it to 0;
    - decrement counter.
  - When counter reaches 1 (the last iteration), the next state is DONE.
  - Sign fix-up (negate quotient and/or remainder per the latched signs) is registered on the DONE transition.
- DONE:
  - out_valid=1; outputs are held stable until out_valid&&out_ready, then the unit returns to IDLE.
  - in_ready=0 in DONE: there is no result/request overlap.
- Latency:
  - Normal: accept edge to out_valid = WIDTH+1 cycles (33 for WIDTH=32).
  - Divide-by-zero or overflow: 1 cycle.
- Back-pressure: out_ready low in DONE stalls indefinitely with no change to the outputs.
- Back-to-back: a new request can be accepted on the cycle after the DONE handshake, at the earliest.
- Results stay on quotient/remainder after return to IDLE; they are meaningful only while out_valid=1.
- rst asserted mid-CALC or in DONE discards the operation; no out_valid is produced.

Optional Feature:
- DIV_FLUSH_EN
- Defined:
  - The flush port exists.
  - flush=1 in CALC or DONE forces IDLE on the next edge with out_valid=0, and the result is dropped.
  - flush in IDLE has no effect and does not block a same-cycle accept; the accept wins.
- Undefined:
  - No flush port; every accepted operation runs to completion.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - the state encoding typedef div_state_t (IDLE=2'd0, CALC=2'd1, DONE=2'd2),
  - localparam DIV_W default,
  - the constant for the divide-by-zero quotient pattern.
- One sub-module, div_sub_step: combinational WIDTH+1-bit trial subtract. Inputs are the partial remainder and the divisor; outputs are the difference and a no_borrow flag. Isolated so it can later be swapped for the prefix-tree adder.

Test Plan:
- Unsigned 100 / 7, out_ready=1 -> out_valid after 33 cycles, quotient=14, remainder=2, div_by_zero=0.
- Signed −100 / 7 -> quotient=0xFFFFFFF2 (−14), remainder=0xFFFFFFFE (−2); signed 100 / −7 -> quotient=−14, remainder=2.
- Divide by zero: dividend=0x1234, divisor=0 -> out_valid next cycle, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> 1-cycle result, quotient=0x80000000, remainder=0.
- Back-pressure: out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0; release -> IDLE, the next request is accepted one cycle later.
- Reset mid-CALC at iteration 16 -> all outputs return to reset values immediately, no out_valid. With DIV_FLUSH_EN, the same check via flush gives IDLE on the next edge.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU execute-stage definitions used by the iterative divider
package cpu_defs_pkg;

    localparam int DIV_W = 32;

    // Divide-by-zero quotient is all ones; the pattern is uniform so any bit replicates to any width
    localparam logic [DIV_W-1:0] DIV_DBZ_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_iter_unit_if.sv
// rtl/div_iter_unit_if.sv - request/result handshake bundle for div_iter_unit (flush with DIV_FLUSH_EN)
interface div_iter_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
`ifdef DIV_FLUSH_EN
    logic             flush;

    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready, flush,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready, flush,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
`endif
endinterface

// File: rtl/div_sub_step.sv
// rtl/div_sub_step.sv - combinational WIDTH+1-bit trial subtract for one restoring-division step
module div_sub_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   part_rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             no_borrow_o
);

    // When no borrow occurs the true difference is below the divisor, so the low WIDTH bits are exact
    assign no_borrow_o = (part_rem_i >= {1'b0, divisor_i});
    assign diff_o      = part_rem_i[WIDTH-1:0] - divisor_i;

endmodule

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - radix-2 restoring divider, RISC-V semantics; DIV_FLUSH_EN adds a flush input
module div_iter_unit
    import cpu_defs_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input logic           clk,
    input logic           rst,
    div_iter_unit_if.slave div
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rout_q, rout_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;

    logic             flush_w;
`ifdef DIV_FLUSH_EN
    assign flush_w = div.flush;
`else
    assign flush_w = 1'b0;
`endif

    logic             accept;
    logic             last_iter;
    logic             sign_dd;
    logic             sign_dv;
    logic             is_dbz;
    logic             is_ovf;
    logic [WIDTH-1:0] mag_dd;
    logic [WIDTH-1:0] mag_dv;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] step_diff;
    logic             step_nb;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;

    assign accept    = div.in_valid && (state_q == IDLE);
    assign last_iter = (cnt_q == CNT_W'(1));
    assign sign_dd   = div.is_signed && div.dividend[WIDTH-1];
    assign sign_dv   = div.is_signed && div.divisor[WIDTH-1];
    assign mag_dd    = sign_dd ? -div.dividend : div.dividend;
    assign mag_dv    = sign_dv ? -div.divisor : div.divisor;
    assign is_dbz    = (div.divisor == '0);
    assign is_ovf    = div.is_signed && (div.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&div.divisor);

    // Dividend register shifts out its MSB into the remainder and collects quotient bits at the LSB
    assign shifted = {rem_q, dvd_q[WIDTH-1]};

    div_sub_step #(.WIDTH(WIDTH)) u_step (
        .part_rem_i  (shifted),
        .divisor_i   (dvs_q),
        .diff_o      (step_diff),
        .no_borrow_o (step_nb)
    );

    assign q_next = {dvd_q[WIDTH-2:0], step_nb};
    assign r_next = step_nb ? step_diff : shifted[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (is_dbz || is_ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush_w) begin
                    state_d = IDLE;
                end else if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (flush_w || div.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div.in_ready    = (state_q == IDLE);
        div.out_valid   = (state_q == DONE);
        div.quotient    = quot_q;
        div.remainder   = rout_q;
        div.div_by_zero = dbz_q;
    end

    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        quot_d     = quot_q;
        rout_d     = rout_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        dbz_d      = dbz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dvd_d      = mag_dd;
                    dvs_d      = mag_dv;
                    neg_quot_d = sign_dd ^ sign_dv;
                    neg_rem_d  = sign_dd;
                    rem_d      = '0;
                    cnt_d      = CNT_W'(WIDTH);
                    dbz_d      = 1'b0;
                    if (is_dbz) begin
                        quot_d = {WIDTH{DIV_DBZ_QUOT[0]}};
                        rout_d = div.dividend;
                        dbz_d  = 1'b1;
                    end else if (is_ovf) begin
                        quot_d = div.dividend;
                        rout_d = '0;
                    end
                end
            end
            CALC: begin
                rem_d = r_next;
                dvd_d = q_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (last_iter) begin
                    quot_d = neg_quot_q ? -q_next : q_next;
                    rout_d = neg_rem_q ? -r_next : r_next;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            quot_q     <= '0;
            rout_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            quot_q     <= quot_d;
            rout_q     <= rout_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            dbz_q      <= dbz_d;
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// tb/tb_div_iter_unit.sv - scoreboard bench for div_iter_unit
module tb_div_iter_unit;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    div_iter_unit_if #(.WIDTH(32)) dif ();

    div_iter_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .div (dif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] dd, input logic [31:0] dv, input logic sgn);
        exp_t e;
        int   a;
        int   b;
        a = $signed(dd);
        b = $signed(dv);
        e.dbz = 1'b0;
        e.lat = 33;
        if (dv == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = dd; e.dbz = 1'b1; e.lat = 1;
        end else if (sgn && dd == 32'h8000_0000 && dv == 32'hFFFF_FFFF) begin
            e.q = dd; e.r = 32'd0; e.lat = 1;
        end else if (sgn) begin
            e.q = 32'(a / b); e.r = 32'(a % b);
        end else begin
            e.q = dd / dv; e.r = dd % dv;
        end
        return e;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 50 && !dif.in_ready; i++) begin
            @(posedge clk); #1;
        end
        check("in_ready_wait", dif.in_ready, 1);
    endtask

    task automatic run_op(input logic [31:0] dd, input logic [31:0] dv, input logic sgn, input int stall);
        int   lat;
        exp_t e;
        wait_ready();
        dif.in_valid  = 1'b1;
        dif.dividend  = dd;
        dif.divisor   = dv;
        dif.is_signed = sgn;
        dif.out_ready = (stall == 0);
        @(posedge clk);
        sb.push_back(model(dd, dv, sgn));
        #1;
        dif.in_valid = 1'b0;
        lat = 1;
        while (!dif.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("hold_valid", dif.out_valid, 1);
            check("hold_in_ready", dif.in_ready, 0);
            check("hold_quot", dif.quotient, sb[0].q);
            check("hold_rem", dif.remainder, sb[0].r);
        end
        dif.out_ready = 1'b1;
        e = sb.pop_front();
        check("out_valid", dif.out_valid, 1);
        check("latency", lat, e.lat);
        check("quotient", dif.quotient, e.q);
        check("remainder", dif.remainder, e.r);
        check("div_by_zero", dif.div_by_zero, e.dbz);
        @(posedge clk); #1;
        check("idle_in_ready", dif.in_ready, 1);
        check("idle_out_valid", dif.out_valid, 0);
    endtask

    task automatic start_and_iterate(input logic [31:0] dd, input logic [31:0] dv, input int iters);
        wait_ready();
        dif.in_valid  = 1'b1;
        dif.dividend  = dd;
        dif.divisor   = dv;
        dif.is_signed = 1'b0;
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        repeat (iters) @(posedge clk);
    endtask

    initial begin
        int seen;
        logic [31:0] rd;
        logic [31:0] rv;
        dif.in_valid  = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        dif.is_signed = 1'b0;
        dif.out_ready = 1'b1;
`ifdef DIV_FLUSH_EN
        dif.flush     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", dif.in_ready, 1);
        check("rst_out_valid", dif.out_valid, 0);
        check("rst_quot", dif.quotient, 0);
        check("rst_rem", dif.remainder, 0);
        check("rst_dbz", dif.div_by_zero, 0);
        rst = 1'b0;

        run_op(32'd100, 32'd7, 1'b0, 0);
        run_op(-32'd100, 32'd7, 1'b1, 0);
        run_op(32'd100, -32'd7, 1'b1, 0);
        run_op(32'h0000_1234, 32'd0, 1'b0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        run_op(32'd5, 32'd10, 1'b0, 0);
        run_op(-32'd7, 32'd0, 1'b1, 0);
        run_op(32'd100, 32'd7, 1'b0, 10);
        for (int i = 0; i < 6; i++) begin
            rd = $urandom;
            rv = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_op(rd, rv, 1'(i % 3 == 0), 0);
        end

        start_and_iterate(32'd1000, 32'd3, 16);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", dif.in_ready, 1);
        check("mid_rst_out_valid", dif.out_valid, 0);
        check("mid_rst_quot", dif.quotient, 0);
        check("mid_rst_rem", dif.remainder, 0);
        check("mid_rst_dbz", dif.div_by_zero, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (dif.out_valid) seen++;
        end
        check("no_valid_after_rst", seen, 0);

`ifdef DIV_FLUSH_EN
        start_and_iterate(32'd1000, 32'd3, 16);
        #1;
        dif.flush = 1'b1;
        @(posedge clk); #1;
        dif.flush = 1'b0;
        check("flush_in_ready", dif.in_ready, 1);
        check("flush_out_valid", dif.out_valid, 0);
        dif.flush     = 1'b1;
        dif.in_valid  = 1'b1;
        dif.dividend  = 32'd81;
        dif.divisor   = 32'd9;
        dif.is_signed = 1'b0;
        @(posedge clk); #1;
        dif.flush    = 1'b0;
        dif.in_valid = 1'b0;
        check("flush_idle_accept", dif.in_ready, 0);
        seen = 0;
        while (!dif.out_valid && seen < 100) begin
            @(posedge clk); #1;
            seen++;
        end
        check("flush_idle_quot", dif.quotient, 32'd9);
        check("flush_idle_rem", dif.remainder, 32'd0);
        @(posedge clk); #1;
`endif
        run_op(32'd12345, 32'd11, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
